// File: rtl/lavanderia_pkg.sv
// Shared encodings for the coin-operated laundry controller: FSM states,
// service selection codes and the bit layout of the actuator pulse vector.
package lavanderia_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNTING = 2'd1,
      VERIFY   = 2'd2,
      PULSE    = 2'd3
   } state_t;

   localparam logic [1:0] SEL_SECADO   = 2'b00;
   localparam logic [1:0] SEL_LAVADO   = 2'b01;
   localparam logic [1:0] SEL_PESADO   = 2'b10;
   localparam logic [1:0] SEL_INVALIDO = 2'b11;

   localparam int unsigned OUT_W     = 4;
   localparam int unsigned OUT_INSUF = 0;
   localparam int unsigned OUT_SEC   = 1;
   localparam int unsigned OUT_LAV   = 2;
   localparam int unsigned OUT_PES   = 3;

   // One-hot actuator vector for a valid service code; zero for SEL_INVALIDO.
   function automatic logic [OUT_W-1:0] sel_onehot(input logic [1:0] sel);
      logic [OUT_W-1:0] v;
      v = '0;
      case (sel)
         SEL_SECADO: v[OUT_SEC] = 1'b1;
         SEL_LAVADO: v[OUT_LAV] = 1'b1;
         SEL_PESADO: v[OUT_PES] = 1'b1;
         default:    v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/lavanderia_multi_pulse_timer.sv
// Loadable down-counter that times the width of the actuator pulses.
module pulse_timer #(
   parameter int unsigned TIMER_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic               i_en,
   input  logic [TIMER_W-1:0] i_value,
   output logic               o_done_c
);

   logic [TIMER_W-1:0] r_count;

   // Load has priority; the counter parks at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - TIMER_W'(1);
      end
   end

   assign o_done_c = (r_count == '0);

endmodule

// File: rtl/lavanderia_multi.sv
// Coin-operated laundry controller: counts credit, verifies payment for the
// selected service, emits a timed actuator pulse and a change strobe.
module lavanderia_multi
   import lavanderia_pkg::*;
#(
   parameter int unsigned COUNT_W      = 4,
   parameter int unsigned PRICE_SECADO = 3,
   parameter int unsigned PRICE_LAVADO = 4,
   parameter int unsigned PRICE_PESADO = 9,
   parameter int unsigned T_SECADO     = 30,
   parameter int unsigned T_LAVADO     = 40,
   parameter int unsigned T_PESADO     = 90,
   parameter int unsigned T_INSUF      = 10,
   parameter int unsigned TIMER_W      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               intro_moneda,
   input  logic               finalizar_pago,
   input  logic [1:0]         seleccion,
   output logic               SECADO,
   output logic               LAVADO,
   output logic               LAVADO_PESADO,
   output logic               insuficiente,
   output logic [COUNT_W-1:0] cambio,
   output logic               cambio_valido,
   output logic               ocupado,
   output logic [COUNT_W-1:0] credito
);

   localparam logic [COUNT_W-1:0] CREDIT_MAX = {COUNT_W{1'b1}};

   state_t             r_state;
   logic [COUNT_W-1:0] r_credito;
   logic [1:0]         r_sel;
   logic               r_ok;
   logic [OUT_W-1:0]   r_out;
   logic [COUNT_W-1:0] r_cambio;
   logic               r_cv;
   logic               r_ocupado;

   state_t             w_state_nxt;
   logic [COUNT_W-1:0] w_cred_nxt;
   logic [1:0]         w_sel_nxt;
   logic               w_ok_nxt;
   logic [OUT_W-1:0]   w_out_nxt;
   logic [COUNT_W-1:0] w_cambio_nxt;
   logic               w_cv_nxt;
   logic               w_load;
   logic               w_tmr_en;
   logic [TIMER_W-1:0] w_load_val;
   logic               w_done;
   logic [31:0]        w_price;
   logic [TIMER_W-1:0] w_time;
   logic [COUNT_W-1:0] w_cred_inc;
   logic               w_pay_ok;

   pulse_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_en     (w_tmr_en),
      .i_value  (w_load_val),
      .o_done_c (w_done)
   );

   // Price and pulse length for the latched selection.
   always_comb begin
      w_price = 32'(PRICE_SECADO);
      w_time  = TIMER_W'(T_SECADO - 1);
      case (r_sel)
         SEL_LAVADO: begin
            w_price = 32'(PRICE_LAVADO);
            w_time  = TIMER_W'(T_LAVADO - 1);
         end
         SEL_PESADO: begin
            w_price = 32'(PRICE_PESADO);
            w_time  = TIMER_W'(T_PESADO - 1);
         end
         default: begin
            w_price = 32'(PRICE_SECADO);
            w_time  = TIMER_W'(T_SECADO - 1);
         end
      endcase
   end

   assign w_cred_inc = (r_credito == CREDIT_MAX) ? r_credito : r_credito + COUNT_W'(1);
   assign w_pay_ok   = (r_sel != SEL_INVALIDO) && (32'(r_credito) >= w_price);

   always_comb begin
      w_state_nxt  = r_state;
      w_cred_nxt   = r_credito;
      w_sel_nxt    = r_sel;
      w_ok_nxt     = r_ok;
      w_out_nxt    = r_out;
      w_cambio_nxt = '0;
      w_cv_nxt     = 1'b0;
      w_load       = 1'b0;
      w_load_val   = '0;
      w_tmr_en     = 1'b0;
      case (r_state)
         IDLE: begin
            w_out_nxt = '0;
            if (intro_moneda) begin
               w_cred_nxt  = COUNT_W'(1);
               w_state_nxt = COUNTING;
            end
         end
         COUNTING: begin
            // A coin arriving with finalizar is counted before verification.
            if (intro_moneda) w_cred_nxt = w_cred_inc;
            if (finalizar_pago) begin
               w_sel_nxt   = seleccion;
               w_state_nxt = VERIFY;
            end
         end
         VERIFY: begin
            w_load      = 1'b1;
            w_state_nxt = PULSE;
            if (w_pay_ok) begin
               w_out_nxt    = sel_onehot(r_sel);
               w_load_val   = w_time;
               w_cambio_nxt = COUNT_W'(32'(r_credito) - w_price);
               w_cv_nxt     = 1'b1;
               w_cred_nxt   = '0;
               w_ok_nxt     = 1'b1;
            end else begin
               w_out_nxt            = '0;
               w_out_nxt[OUT_INSUF] = 1'b1;
               w_load_val           = TIMER_W'(T_INSUF - 1);
               w_ok_nxt             = 1'b0;
            end
         end
         PULSE: begin
            w_tmr_en = 1'b1;
            if (w_done) begin
               w_out_nxt   = '0;
               w_state_nxt = r_ok ? IDLE : COUNTING;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_credito <= '0;
         r_sel     <= '0;
         r_ok      <= 1'b0;
         r_out     <= '0;
         r_cambio  <= '0;
         r_cv      <= 1'b0;
         r_ocupado <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_credito <= w_cred_nxt;
         r_sel     <= w_sel_nxt;
         r_ok      <= w_ok_nxt;
         r_out     <= w_out_nxt;
         r_cambio  <= w_cambio_nxt;
         r_cv      <= w_cv_nxt;
         r_ocupado <= (w_state_nxt == VERIFY) || (w_state_nxt == PULSE);
      end
   end

   assign SECADO        = r_out[OUT_SEC];
   assign LAVADO        = r_out[OUT_LAV];
   assign LAVADO_PESADO = r_out[OUT_PES];
   assign insuficiente  = r_out[OUT_INSUF];
   assign cambio        = r_cambio;
   assign cambio_valido = r_cv;
   assign ocupado       = r_ocupado;
   assign credito       = r_credito;

endmodule

// File: tb/tb_lavanderia_multi.sv
// Scoreboard bench for lavanderia_multi: stimulus queues expected pulses and
// change values; a negedge monitor measures the DUT outputs against them.
module tb_lavanderia_multi;

   localparam int unsigned COUNT_W = 4;
   localparam int unsigned TIMER_W = 8;

   localparam int K_INS = 1;
   localparam int K_SEC = 2;
   localparam int K_LAV = 4;
   localparam int K_PES = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               intro_moneda;
   logic               finalizar_pago;
   logic [1:0]         seleccion;
   logic               SECADO;
   logic               LAVADO;
   logic               LAVADO_PESADO;
   logic               insuficiente;
   logic [COUNT_W-1:0] cambio;
   logic               cambio_valido;
   logic               ocupado;
   logic [COUNT_W-1:0] credito;

   lavanderia_multi #(
      .COUNT_W(COUNT_W), .PRICE_SECADO(3), .PRICE_LAVADO(4), .PRICE_PESADO(9),
      .T_SECADO(30), .T_LAVADO(40), .T_PESADO(90), .T_INSUF(10), .TIMER_W(TIMER_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .intro_moneda   (intro_moneda),
      .finalizar_pago (finalizar_pago),
      .seleccion      (seleccion),
      .SECADO         (SECADO),
      .LAVADO         (LAVADO),
      .LAVADO_PESADO  (LAVADO_PESADO),
      .insuficiente   (insuficiente),
      .cambio         (cambio),
      .cambio_valido  (cambio_valido),
      .ocupado        (ocupado),
      .credito        (credito)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int len;
      int start;
   } pulse_t;

   pulse_t exp_pulse[$];
   int     exp_cambio[$];
   int     n_checks = 0;
   int     n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pulse kind/length/start, exclusivity and change strobe.
   logic [3:0] prev_act = 4'd0;
   int         p_start  = 0;
   int         p_kind   = 0;

   always @(negedge clk) begin
      logic [3:0] act;
      pulse_t     e;
      act = {LAVADO_PESADO, LAVADO, SECADO, insuficiente};
      chk("exclusive", int'($countones(act) <= 1), 1);
      if (act != 4'd0 && prev_act == 4'd0) begin
         p_start = cyc;
         p_kind  = int'(act);
      end
      if (act == 4'd0 && prev_act != 4'd0) begin
         if (exp_pulse.size() == 0) begin
            chk("unexpected_pulse", p_kind, 0);
         end else begin
            e = exp_pulse.pop_front();
            chk("pulse_kind", p_kind, e.kind);
            chk("pulse_len", cyc - p_start, e.len);
            chk("pulse_start", p_start, e.start);
         end
      end
      prev_act = act;
      if (cambio_valido) begin
         if (exp_cambio.size() == 0) chk("unexpected_cambio", int'(cambio_valido), 0);
         else chk("cambio", int'(cambio), exp_cambio.pop_front());
      end else begin
         chk("cambio_idle_zero", int'(cambio), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coins(input int n);
      intro_moneda = 1'b1;
      repeat (n) tick();
      intro_moneda = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (ocupado && n < bound) begin
         tick();
         n++;
      end
      chk("busy_timeout", int'(ocupado), 0);
   endtask

   // Issue finalizar and queue the expected outcome; chg < 0 means no change strobe.
   task automatic finish(input logic [1:0] sel, input int kind, input int len,
                         input int chg, input bit coin_with, input bit coin_during);
      pulse_t e;
      seleccion      = sel;
      finalizar_pago = 1'b1;
      intro_moneda   = coin_with;
      e.kind  = kind;
      e.len   = len;
      e.start = cyc + 2;
      exp_pulse.push_back(e);
      if (chg >= 0) exp_cambio.push_back(chg);
      tick();
      finalizar_pago = 1'b0;
      intro_moneda   = coin_during;
      seleccion      = ~sel;
      chk("busy_after_finalizar", int'(ocupado), 1);
      wait_idle(len + 20);
      intro_moneda = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      pulse_t e;
      int     n;
      rst            = 1'b1;
      intro_moneda   = 1'b0;
      finalizar_pago = 1'b0;
      seleccion      = 2'b00;
      repeat (3) tick();
      chk("reset_credito", int'(credito), 0);
      chk("reset_ocupado", int'(ocupado), 0);
      chk("reset_outputs", int'({SECADO, LAVADO, LAVADO_PESADO, insuficiente, cambio_valido}), 0);
      rst = 1'b0;
      tick();

      // finalizar alone in IDLE is ignored
      finalizar_pago = 1'b1;
      tick();
      finalizar_pago = 1'b0;
      tick();
      chk("idle_finalizar_ignored", int'(ocupado), 0);

      // 3 coins, secado
      coins(3);
      chk("credito_3", int'(credito), 3);
      finish(2'b00, K_SEC, 30, 0, 1'b0, 1'b0);
      chk("credito_after_secado", int'(credito), 0);

      // 11 coins, pesado with change 2
      coins(11);
      chk("credito_11", int'(credito), 11);
      finish(2'b10, K_PES, 90, 2, 1'b0, 1'b0);
      chk("credito_after_pesado", int'(credito), 0);

      // insufficient then top-up
      coins(2);
      finish(2'b01, K_INS, 10, -1, 1'b0, 1'b0);
      chk("credito_retained_2", int'(credito), 2);
      coins(2);
      chk("credito_4", int'(credito), 4);
      finish(2'b01, K_LAV, 40, 0, 1'b0, 1'b0);
      chk("credito_after_lavado", int'(credito), 0);

      // invalid selection, coins during busy window ignored
      coins(5);
      finish(2'b11, K_INS, 10, -1, 1'b0, 1'b1);
      chk("credito_retained_5", int'(credito), 5);
      finish(2'b00, K_SEC, 30, 2, 1'b0, 1'b0);
      chk("credito_after_retry", int'(credito), 0);

      // reset at cycle 20 of a lavado pulse
      coins(4);
      seleccion      = 2'b01;
      finalizar_pago = 1'b1;
      e.kind  = K_LAV;
      e.len   = 20;
      e.start = cyc + 2;
      exp_pulse.push_back(e);
      exp_cambio.push_back(0);
      tick();
      finalizar_pago = 1'b0;
      n = 0;
      while (!LAVADO && n < 10) begin
         tick();
         n++;
      end
      chk("lavado_started", int'(LAVADO), 1);
      repeat (19) tick();
      rst = 1'b1;
      tick();
      chk("midreset_outputs", int'({SECADO, LAVADO, LAVADO_PESADO, insuficiente, cambio_valido}), 0);
      chk("midreset_credito", int'(credito), 0);
      chk("midreset_ocupado", int'(ocupado), 0);
      rst = 1'b0;
      coins(1);
      chk("coin_after_reset", int'(credito), 1);
      coins(2);
      finish(2'b00, K_SEC, 30, 0, 1'b0, 1'b0);

      // saturation
      coins(17);
      chk("credito_saturated", int'(credito), 15);
      finish(2'b00, K_SEC, 30, 12, 1'b0, 1'b0);
      chk("credito_after_sat", int'(credito), 0);

      // coin and finalizar in the same cycle
      coins(2);
      chk("credito_2_before_combo", int'(credito), 2);
      finish(2'b00, K_SEC, 30, 0, 1'b1, 1'b0);
      chk("credito_after_combo", int'(credito), 0);

      repeat (5) tick();
      chk("pulse_queue_drained", exp_pulse.size(), 0);
      chk("cambio_queue_drained", exp_cambio.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
